// File: rtl/seven_segment_capture.sv
// Receive-side decoder for a multiplexed 8-digit seven-segment bus; rebuilds the 32-bit hex word.
// Optional per-digit decimal-point capture is enabled by defining SEG_CAPTURE_DP_EN.
module seven_segment_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seg_in,
  output logic [31:0] num_out,
  output logic        num_valid,
  output logic        code_err,
  output logic        frame_timeout,
  output logic [7:0]  dp_out
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Returns {valid, nibble}; bit 7 of the cathode code never takes part in the match.
  function automatic logic [4:0] decode_glyph(input logic [6:0] code);
    logic [4:0] res;
    case (code)
      7'h40:   res = 5'h10;
      7'h79:   res = 5'h11;
      7'h24:   res = 5'h12;
      7'h30:   res = 5'h13;
      7'h19:   res = 5'h14;
      7'h12:   res = 5'h15;
      7'h02:   res = 5'h16;
      7'h78:   res = 5'h17;
      7'h00:   res = 5'h18;
      7'h18:   res = 5'h19;
      7'h08:   res = 5'h1A;
      7'h03:   res = 5'h1B;
      7'h27:   res = 5'h1C;
      7'h21:   res = 5'h1D;
      7'h06:   res = 5'h1E;
      7'h0E:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  state_t         state_r, state_next_s;
  logic [15:0]    seg_q_r, seg_prev_r;
  logic [CW-1:0]  cnt_r, cnt_next_s;
  logic [TW-1:0]  tmr_r;
  logic [31:0]    shadow_r, shadow_upd_s, num_out_r;
  logic [7:0]     mask_r, mask_upd_s;
  logic           num_valid_r, code_err_r, frame_timeout_r;
  logic           sel_valid_s, changed_s, settle_done_s, cap_ok_s, frame_done_s;
  logic [2:0]     digit_s;
  logic [3:0]     zeros_s;
  logic [4:0]     glyph_s;

  // Select decode: exactly one low bit in the select field names the active digit.
  always_comb begin
    zeros_s = 4'd0;
    digit_s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!seg_q_r[i]) begin
        zeros_s = zeros_s + 4'd1;
        digit_s = 3'(i);
      end else begin
        zeros_s = zeros_s;
      end
    end
    sel_valid_s = (zeros_s == 4'd1);
    changed_s   = (seg_q_r != seg_prev_r);
    glyph_s     = decode_glyph(seg_q_r[14:8]);
  end

  // FSM next-state: settle window, one capture per select dwell.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    settle_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_valid_s) begin
          state_next_s = SETTLE;
          cnt_next_s   = {CW{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      SETTLE: begin
        if (!sel_valid_s) begin
          state_next_s = IDLE;
          cnt_next_s   = {CW{1'b0}};
        end else if (changed_s) begin
          cnt_next_s = {CW{1'b0}};
        end else if (cnt_r == CW'(SETTLE_CYCLES - 1)) begin
          settle_done_s = 1'b1;
          state_next_s  = HOLD;
          cnt_next_s    = {CW{1'b0}};
        end else begin
          cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      HOLD: begin
        if (!sel_valid_s) begin
          state_next_s = IDLE;
        end else if (changed_s) begin
          state_next_s = SETTLE;
          cnt_next_s   = {CW{1'b0}};
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // Shadow/mask update including the nibble captured this cycle.
  always_comb begin
    cap_ok_s     = settle_done_s & glyph_s[4];
    shadow_upd_s = shadow_r;
    mask_upd_s   = mask_r;
    if (cap_ok_s) begin
      shadow_upd_s[digit_s*4 +: 4] = glyph_s[3:0];
      mask_upd_s[digit_s]          = 1'b1;
    end else begin
      mask_upd_s = mask_r;
    end
    frame_done_s = cap_ok_s && (mask_upd_s == 8'hFF);
  end

  // Input sampling, FSM state, frame assembly and timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q_r         <= 16'hFFFF;
      seg_prev_r      <= 16'hFFFF;
      state_r         <= IDLE;
      cnt_r           <= {CW{1'b0}};
      tmr_r           <= {TW{1'b0}};
      shadow_r        <= 32'h0000_0000;
      mask_r          <= 8'h00;
      num_out_r       <= 32'h0000_0000;
      num_valid_r     <= 1'b0;
      code_err_r      <= 1'b0;
      frame_timeout_r <= 1'b0;
    end else begin
      seg_q_r         <= seg_in;
      seg_prev_r      <= seg_q_r;
      state_r         <= state_next_s;
      cnt_r           <= cnt_next_s;
      shadow_r        <= shadow_upd_s;
      num_valid_r     <= 1'b0;
      code_err_r      <= settle_done_s & ~glyph_s[4];
      frame_timeout_r <= 1'b0;
      if (frame_done_s) begin
        num_out_r   <= shadow_upd_s;
        num_valid_r <= 1'b1;
        mask_r      <= 8'h00;
        tmr_r       <= {TW{1'b0}};
      end else if (cap_ok_s || (mask_r == 8'h00)) begin
        mask_r <= mask_upd_s;
        tmr_r  <= {TW{1'b0}};
      end else if (tmr_r == TW'(FRAME_TIMEOUT - 1)) begin
        // Stale partial frame: drop it but keep the last good word.
        mask_r          <= 8'h00;
        frame_timeout_r <= 1'b1;
        tmr_r           <= {TW{1'b0}};
      end else begin
        tmr_r <= tmr_r + {{(TW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign num_out       = num_out_r;
  assign num_valid     = num_valid_r;
  assign code_err      = code_err_r;
  assign frame_timeout = frame_timeout_r;

`ifdef SEG_CAPTURE_DP_EN
  logic [7:0] dp_shadow_r, dp_upd_s, dp_out_r;

  // Decimal-point shadow follows the nibble capture; lit segment is active-low.
  always_comb begin
    dp_upd_s = dp_shadow_r;
    if (cap_ok_s) begin
      dp_upd_s[digit_s] = ~seg_q_r[15];
    end else begin
      dp_upd_s = dp_shadow_r;
    end
  end

  // Decimal-point registers, published together with num_out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dp_shadow_r <= 8'h00;
      dp_out_r    <= 8'h00;
    end else begin
      dp_shadow_r <= dp_upd_s;
      if (frame_done_s) begin
        dp_out_r <= dp_upd_s;
      end else begin
        dp_out_r <= dp_out_r;
      end
    end
  end

  assign dp_out = dp_out_r;
`else
  assign dp_out = 8'h00;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: directed frames, glitch/lag, bad glyph, timeout, reset.
module tb_seven_segment_capture;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 1000;
  localparam int DWELL   = 50;
`ifdef SEG_CAPTURE_DP_EN
  localparam logic [7:0] DP_EXP = 8'h81;
`else
  localparam logic [7:0] DP_EXP = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] seg_in = 16'hFFFF;
  logic [31:0] num_out;
  logic        num_valid, code_err, frame_timeout;
  logic [7:0]  dp_out;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_tmo    = 0;
  logic [39:0] exp_q[$];

  seven_segment_capture #(.SETTLE_CYCLES(SETTLE), .FRAME_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .num_out(num_out), .num_valid(num_valid),
    .code_err(code_err), .frame_timeout(frame_timeout), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every num_valid, counts other pulses.
  always @(negedge clk) begin
    if (num_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_valid: got num_out %h, expected no word", num_out);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("num_out", num_out, e[31:0]);
        check("dp_out", {24'h0, dp_out}, {24'h0, e[39:32]});
      end
    end
    if (code_err) n_err++;
    if (frame_timeout) n_tmo++;
  end

  logic [7:0] prev_code;

  task automatic send_digit(input int k, input logic [7:0] code, input bit lag, input int dwell);
    logic [7:0] sel;
    sel = ~(8'h01 << k);
    @(negedge clk);
    if (lag) begin
      seg_in = {prev_code, sel};
      @(negedge clk);
    end
    seg_in = {code, sel};
    repeat (dwell - 1) @(negedge clk);
    prev_code = code;
  endtask

  task automatic send_frame(input logic [31:0] v, input logic [7:0] dpm, input bit lag, input int first, input int last);
    for (int k = first; k <= last; k++)
      send_digit(k, {~dpm[k], glyph(v[4*k +: 4])}, lag, DWELL);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    seg_in = 16'hFFFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d words pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int v0, e0, t0;
    prev_code = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_num_out", num_out, 32'h0);
    check("rst_num_valid", {31'h0, num_valid}, 32'h0);
    check("rst_code_err", {31'h0, code_err}, 32'h0);
    check("rst_frame_timeout", {31'h0, frame_timeout}, 32'h0);
    check("rst_dp_out", {24'h0, dp_out}, 32'h0);
    reset = 1'b1;
    idle(3);

    // Plain frame
    exp_q.push_back({8'h00, 32'h01234567});
    send_frame(32'h01234567, 8'h00, 1'b0, 0, 7);
    idle(5);
    wait_drain("frame1");
    check("frame1_valid_cnt", n_valid, 1);
    check("frame1_code_err", n_err, 0);

    // Select leads code by one cycle on every digit
    exp_q.push_back({8'h00, 32'h89ABCDEF});
    send_frame(32'h89ABCDEF, 8'h00, 1'b1, 0, 7);
    idle(5);
    wait_drain("lag");
    check("lag_code_err", n_err, 0);

    // Bad glyph on digit 3, two dwells, then the good one
    v0 = n_valid;
    exp_q.push_back({8'h00, 32'hCAFE1234});
    send_frame(32'hCAFE1234, 8'h00, 1'b0, 0, 2);
    send_digit(3, 8'hFF, 1'b0, DWELL);
    idle(2);
    send_digit(3, 8'hFF, 1'b0, DWELL);
    idle(2);
    check("bad_glyph_err_cnt", n_err, 2);
    check("bad_glyph_no_valid", n_valid, v0);
    send_frame(32'hCAFE1234, 8'h00, 1'b0, 3, 7);
    idle(5);
    wait_drain("bad_glyph");

    // Partial frame timeout
    v0 = n_valid;
    t0 = n_tmo;
    send_frame(32'h55555555, 8'h00, 1'b0, 0, 5);
    idle(TIMEOUT + 50);
    check("timeout_pulse", n_tmo, t0 + 1);
    check("timeout_no_valid", n_valid, v0);
    check("timeout_num_out_kept", num_out, 32'hCAFE1234);
    exp_q.push_back({8'h00, 32'h13579BDF});
    send_frame(32'h13579BDF, 8'h00, 1'b0, 0, 7);
    idle(5);
    wait_drain("after_timeout");

    // Reset after four captures
    v0 = n_valid;
    e0 = n_err;
    t0 = n_tmo;
    send_frame(32'h77777777, 8'h00, 1'b0, 0, 3);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_num_out", num_out, 32'h0);
    check("mid_rst_dp_out", {24'h0, dp_out}, 32'h0);
    reset = 1'b1;
    idle(3);
    check("mid_rst_no_pulses", n_valid + n_err + n_tmo, v0 + e0 + t0);
    exp_q.push_back({8'h00, 32'hDEADBEEF});
    send_frame(32'hDEADBEEF, 8'h00, 1'b0, 0, 7);
    idle(5);
    wait_drain("deadbeef");

    // Decimal points lit on digits 0 and 7
    exp_q.push_back({DP_EXP, 32'h24681357});
    send_frame(32'h24681357, 8'h81, 1'b0, 0, 7);
    idle(5);
    wait_drain("dp");
    check("total_valid_cnt", n_valid, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
